// File: rtl/otg_hpi_access_sequencer.sv
// Hardware sequencer for single 16-bit CY7C67200 HPI accesses.
// Generates CS/RD/WR/address/data timing with programmable setup, strobe, hold and recovery.
module otg_hpi_access_sequencer #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in
);

  localparam int unsigned MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned MAX_SR  = (STROBE_CYC > RECOVERY_CYC) ? STROBE_CYC : RECOVERY_CYC;
  localparam int unsigned MAX_CYC = (MAX_SH > MAX_SR) ? MAX_SH : MAX_SR;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_write;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  // Phase sequencing: every timed state loads (N-1) on entry and leaves when the counter hits zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      is_write     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rdata        <= '0;
      otg_addr     <= '0;
      otg_cs_n     <= 1'b1;
      otg_rd_n     <= 1'b1;
      otg_wr_n     <= 1'b1;
      otg_data_out <= '0;
      otg_data_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            is_write <= req_write;
            otg_addr <= req_addr;
            otg_cs_n <= 1'b0;
            busy     <= 1'b1;
            cnt      <= CNT_W'(SETUP_CYC - 1);
            state    <= S_SETUP;
            if (req_write) begin
              otg_data_out <= req_wdata;
              otg_data_oe  <= 1'b1;
            end else begin
              otg_data_oe  <= 1'b0;
            end
          end
        end

        S_SETUP: begin
          if (cnt_zero) begin
            cnt   <= CNT_W'(STROBE_CYC - 1);
            state <= S_STROBE;
            if (is_write) begin
              otg_wr_n <= 1'b0;
            end else begin
              otg_rd_n <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_STROBE: begin
          if (cnt_zero) begin
            otg_rd_n <= 1'b1;
            otg_wr_n <= 1'b1;
            cnt      <= CNT_W'(HOLD_CYC - 1);
            state    <= S_HOLD;
            // Read data is taken on the edge that ends the strobe.
            if (!is_write) begin
              rdata <= otg_data_in;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (cnt_zero) begin
            otg_cs_n    <= 1'b1;
            otg_data_oe <= 1'b0;
            cnt         <= CNT_W'(RECOVERY_CYC - 1);
            state       <= S_RECOVER;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_RECOVER: begin
          if (cnt_zero) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          otg_cs_n    <= 1'b1;
          otg_rd_n    <= 1'b1;
          otg_wr_n    <= 1'b1;
          otg_data_oe <= 1'b0;
          busy        <= 1'b0;
          cnt         <= '0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otg_hpi_access_sequencer.sv
// Bench for otg_hpi_access_sequencer: a default-timing instance and a swept-timing instance,
// each checked every cycle against a timeline model plus literal phase-width expectations.
module tb_otg_hpi_access_sequencer;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req         [NI];
  logic        req_write   [NI];
  logic [1:0]  req_addr    [NI];
  logic [15:0] req_wdata   [NI];
  logic [15:0] otg_data_in [NI];
  logic        busy        [NI];
  logic        done        [NI];
  logic [15:0] rdata       [NI];
  logic [1:0]  otg_addr    [NI];
  logic        otg_cs_n    [NI];
  logic        otg_rd_n    [NI];
  logic        otg_wr_n    [NI];
  logic [15:0] otg_data_out[NI];
  logic        otg_data_oe [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  otg_hpi_access_sequencer u_dut_def (
    .clk(clk), .reset(reset), .req(req[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .busy(busy[0]), .done(done[0]),
    .rdata(rdata[0]), .otg_addr(otg_addr[0]), .otg_cs_n(otg_cs_n[0]),
    .otg_rd_n(otg_rd_n[0]), .otg_wr_n(otg_wr_n[0]), .otg_data_out(otg_data_out[0]),
    .otg_data_oe(otg_data_oe[0]), .otg_data_in(otg_data_in[0])
  );

  otg_hpi_access_sequencer #(
    .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .RECOVERY_CYC(1)
  ) u_dut_swp (
    .clk(clk), .reset(reset), .req(req[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .busy(busy[1]), .done(done[1]),
    .rdata(rdata[1]), .otg_addr(otg_addr[1]), .otg_cs_n(otg_cs_n[1]),
    .otg_rd_n(otg_rd_n[1]), .otg_wr_n(otg_wr_n[1]), .otg_data_out(otg_data_out[1]),
    .otg_data_oe(otg_data_oe[1]), .otg_data_in(otg_data_in[1])
  );

  // Phase lengths per instance: k = 0 setup, 1 strobe, 2 hold, 3 recovery.
  function automatic int ph(input int i, input int k);
    if (i == 0) begin
      case (k)
        0: return 1;
        1: return 4;
        2: return 1;
        default: return 2;
      endcase
    end
    case (k)
      0: return 2;
      1: return 1;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, inst, act, exp);
    end
  endtask

  // Timeline model: m_t counts cycles since the accepting edge (0 = idle).
  bit          m_valid [NI];
  int          m_t     [NI];
  bit          m_wr    [NI];
  bit          m_done  [NI];
  logic [1:0]  m_addr  [NI];
  logic [15:0] m_wdata [NI];
  logic [15:0] m_rdata [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_valid[i] <= 1'b1;
        m_t[i]     <= 0;
        m_done[i]  <= 1'b0;
        m_rdata[i] <= 16'h0;
        m_addr[i]  <= 2'd0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_t[i] == 0) begin
          if (req[i] === 1'b1) begin
            m_t[i]     <= 1;
            m_wr[i]    <= req_write[i];
            m_addr[i]  <= req_addr[i];
            m_wdata[i] <= req_wdata[i];
          end
        end else begin
          if (!m_wr[i] && m_t[i] == ph(i, 0) + ph(i, 1))
            m_rdata[i] <= otg_data_in[i];
          if (m_t[i] == ph(i, 0) + ph(i, 1) + ph(i, 2) + ph(i, 3)) begin
            m_t[i]    <= 0;
            m_done[i] <= 1'b1;
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    int  t, s, st, h;
    bit  in_strobe, in_cs;
    for (int i = 0; i < NI; i++) begin
      if (m_valid[i]) begin
        t  = m_t[i];
        s  = ph(i, 0);
        st = ph(i, 1);
        h  = ph(i, 2);
        in_strobe = (t > s) && (t <= s + st);
        in_cs     = (t >= 1) && (t <= s + st + h);
        check("busy",     i, busy[i],        t != 0);
        check("done",     i, done[i],        m_done[i]);
        check("rdata",    i, rdata[i],       m_rdata[i]);
        check("otg_addr", i, otg_addr[i],    m_addr[i]);
        check("cs_n",     i, otg_cs_n[i],    !in_cs);
        check("rd_n",     i, otg_rd_n[i],    !(in_strobe && !m_wr[i]));
        check("wr_n",     i, otg_wr_n[i],    !(in_strobe && m_wr[i]));
        check("oe",       i, otg_data_oe[i], in_cs && m_wr[i]);
        if (in_cs && m_wr[i])
          check("data_out", i, otg_data_out[i], m_wdata[i]);
        check("strobe_excl", i, !(otg_rd_n[i] === 1'b0 && otg_wr_n[i] === 1'b0), 1);
      end
    end
  end

  // Edge timestamps of the DUT pins, used for literal phase-width checks.
  int   cyc[NI], cs_fall[NI], cs_rise[NI], cs_len[NI], cs_gap[NI];
  int   stb_fall[NI], stb_rise[NI], wr_len[NI], rd_len[NI], oe_rise[NI], oe_len[NI];
  int   busy_fall[NI], done_cyc[NI], done_cnt[NI];
  logic prev_cs[NI], prev_stb[NI], prev_wr[NI], prev_oe[NI], prev_busy[NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (m_valid[i]) begin
        cyc[i] <= cyc[i] + 1;
        if (prev_cs[i] === 1'b1 && otg_cs_n[i] === 1'b0) begin
          cs_fall[i] <= cyc[i];
          cs_gap[i]  <= cyc[i] - cs_rise[i];
        end
        if (prev_cs[i] === 1'b0 && otg_cs_n[i] === 1'b1) begin
          cs_rise[i] <= cyc[i];
          cs_len[i]  <= cyc[i] - cs_fall[i];
        end
        if (prev_stb[i] === 1'b1 && (otg_rd_n[i] & otg_wr_n[i]) === 1'b0)
          stb_fall[i] <= cyc[i];
        if (prev_stb[i] === 1'b0 && (otg_rd_n[i] & otg_wr_n[i]) === 1'b1) begin
          stb_rise[i] <= cyc[i];
          if (prev_wr[i] === 1'b0) wr_len[i] <= cyc[i] - stb_fall[i];
          else                     rd_len[i] <= cyc[i] - stb_fall[i];
        end
        if (prev_oe[i] === 1'b0 && otg_data_oe[i] === 1'b1) oe_rise[i] <= cyc[i];
        if (prev_oe[i] === 1'b1 && otg_data_oe[i] === 1'b0) oe_len[i] <= cyc[i] - oe_rise[i];
        if (prev_busy[i] === 1'b1 && busy[i] === 1'b0) busy_fall[i] <= cyc[i];
        if (done[i] === 1'b1) begin
          done_cyc[i] <= cyc[i];
          done_cnt[i] <= done_cnt[i] + 1;
        end
        prev_cs[i]   <= otg_cs_n[i];
        prev_stb[i]  <= otg_rd_n[i] & otg_wr_n[i];
        prev_wr[i]   <= otg_wr_n[i];
        prev_oe[i]   <= otg_data_oe[i];
        prev_busy[i] <= busy[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int i, input logic w, input logic [1:0] a, input logic [15:0] d);
    req[i]       = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    tick(1);
    req[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (done[i] !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check("done_wait", i, done[i], 1'b1);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int dc;
    for (int i = 0; i < NI; i++) begin
      req[i]         = (i == 0);
      req_write[i]   = 1'b1;
      req_addr[i]    = 2'd3;
      req_wdata[i]   = 16'hFFFF;
      otg_data_in[i] = 16'h0000;
    end
    reset = 1'b1;
    tick(2);
    check("rst_cs_n",  0, otg_cs_n[0], 1'b1);
    check("rst_rd_n",  0, otg_rd_n[0], 1'b1);
    check("rst_wr_n",  0, otg_wr_n[0], 1'b1);
    check("rst_addr",  0, otg_addr[0], 2'd0);
    check("rst_dout",  0, otg_data_out[0], 16'h0);
    check("rst_oe",    0, otg_data_oe[0], 1'b0);
    check("rst_rdata", 0, rdata[0], 16'h0);
    check("rst_busy",  0, busy[0], 1'b0);
    check("rst_done",  0, done[0], 1'b0);
    check("rst_busy",  1, busy[1], 1'b0);
    reset  = 1'b0;
    req[0] = 1'b0;
    tick(1);

    // Default-timing write.
    dc = done_cnt[0];
    start(0, 1'b1, 2'd2, 16'h1234);
    wait_done(0, 20);
    check("wr_cs_len",   0, cs_len[0], 6);
    check("wr_strobe",   0, wr_len[0], 4);
    check("wr_oe_len",   0, oe_len[0], 6);
    check("wr_addr",     0, otg_addr[0], 2'd2);
    check("wr_done_lat", 0, done_cyc[0] - (cs_fall[0] - 1), 9);
    check("wr_rdata",    0, rdata[0], 16'h0);
    check("wr_done_cnt", 0, done_cnt[0] - dc, 1);

    // Read, then a write that must leave rdata alone.
    otg_data_in[0] = 16'hBEEF;
    start(0, 1'b0, 2'd0, 16'h0000);
    wait_done(0, 20);
    check("rd_strobe", 0, rd_len[0], 4);
    check("rd_rdata",  0, rdata[0], 16'hBEEF);
    otg_data_in[0] = 16'h5555;
    start(0, 1'b1, 2'd1, 16'hA5A5);
    wait_done(0, 20);
    check("wr2_rdata", 0, rdata[0], 16'hBEEF);

    // Back-to-back with req held, plus an ignored mid-access pulse.
    dc = done_cnt[0];
    otg_data_in[0] = 16'h1357;
    req[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 2'd3; req_wdata[0] = 16'h0F0F;
    tick(1);
    req_write[0] = 1'b0; req_addr[0] = 2'd0;
    wait_done(0, 20);
    tick(1);
    req[0] = 1'b0;
    tick(2);
    req[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 2'd1; req_wdata[0] = 16'hDEAD;
    tick(1);
    req[0] = 1'b0;
    wait_done(0, 20);
    check("b2b_gap",   0, cs_gap[0], 3);
    check("b2b_done",  0, done_cnt[0] - dc, 2);
    check("b2b_rdata", 0, rdata[0], 16'h1357);
    tick(12);
    check("b2b_idle",  0, busy[0], 1'b0);
    check("b2b_nodup", 0, done_cnt[0] - dc, 2);

    // Reset during the write strobe aborts the access.
    dc = done_cnt[0];
    start(0, 1'b1, 2'd2, 16'h7777);
    tick(2);
    check("abt_in_strobe", 0, otg_wr_n[0], 1'b0);
    reset = 1'b1;
    tick(1);
    check("abt_wr_n", 0, otg_wr_n[0], 1'b1);
    check("abt_cs_n", 0, otg_cs_n[0], 1'b1);
    check("abt_oe",   0, otg_data_oe[0], 1'b0);
    check("abt_busy", 0, busy[0], 1'b0);
    reset = 1'b0;
    tick(12);
    settle();
    check("abt_nodone", 0, done_cnt[0] - dc, 0);

    // Swept timing 2/1/3/1.
    otg_data_in[1] = 16'hC0DE;
    start(1, 1'b0, 2'd3, 16'h0000);
    wait_done(1, 20);
    check("swp_setup",  1, stb_fall[1] - cs_fall[1], 2);
    check("swp_strobe", 1, rd_len[1], 1);
    check("swp_hold",   1, cs_rise[1] - stb_rise[1], 3);
    check("swp_recov",  1, busy_fall[1] - cs_rise[1], 1);
    check("swp_rdata",  1, rdata[1], 16'hC0DE);
    start(1, 1'b1, 2'd2, 16'h4242);
    wait_done(1, 20);
    check("swp_wsetup", 1, stb_fall[1] - cs_fall[1], 2);
    check("swp_wstrb",  1, wr_len[1], 1);
    check("swp_whold",  1, cs_rise[1] - stb_rise[1], 3);
    check("swp_wrdata", 1, rdata[1], 16'hC0DE);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
